// File: rtl/msrh_conf_pkg.sv
// Core-wide configuration constants shared by the rename/commit blocks.
package msrh_conf_pkg;

  // Instructions dispatched together as one commit group.
  localparam int DISP_SIZE = 2;

endpackage

// File: rtl/msrh_pkg.sv
// Shared types for the commit side: group entry, commit-ID width, and the
// rename-ID update handed back to the rename stage.
package msrh_pkg;

  localparam int RNID_W     = 6;
  localparam int CMT_DEPTH  = 16;
  localparam int CMT_IDX_W  = $clog2(CMT_DEPTH);
  // One extra MSB acts as the wrap bit so full and empty are distinguishable.
  localparam int CMT_BLK_W  = CMT_IDX_W + 1;
  localparam int CMT_SLOT_W = (msrh_conf_pkg::DISP_SIZE > 1) ? $clog2(msrh_conf_pkg::DISP_SIZE) : 1;

  typedef logic [CMT_BLK_W-1:0] cmt_id_t;

  // One in-order buffer entry: rename info captured at dispatch plus
  // per-slot completion state collected from the done ports.
  typedef struct packed {
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             inst_valid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             rd_valid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][4:0]        rd_regidx;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0] rd_rnid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0] old_rnid;
    logic                                            is_br_included;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             done;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             mispred;
  } cmt_grp_t;

  // Commit update consumed by the rename freelist and map.
  typedef struct packed {
    logic                                            commit;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             rnid_valid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][4:0]        rd_regidx;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0] rd_rnid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0] old_rnid;
    logic                                            is_br_included;
    logic                                            upd_pc_valid;
    logic [msrh_conf_pkg::DISP_SIZE-1:0]             dead_id;
  } cmt_rnid_upd_t;

  // An ID is live when it lies in [head, tail) on the wrapping ID circle.
  // Distances are taken modulo 2^CMT_BLK_W, which is exact because the
  // occupancy never exceeds CMT_DEPTH.
  function automatic logic cmt_id_is_live(input cmt_id_t id,
                                          input cmt_id_t head,
                                          input cmt_id_t tail);
    cmt_id_t offset;
    cmt_id_t occupancy;
    offset    = id - head;
    occupancy = tail - head;
    return offset < occupancy;
  endfunction

endpackage

// File: rtl/msrh_rnid_commit_tracker.sv
// In-order commit tracker: records dispatched groups with their rename IDs,
// collects per-slot completion, and retires the oldest complete group by
// emitting one rename-ID update (with map restore on mispredict).
module msrh_rnid_commit_tracker
  import msrh_pkg::*;
#(
  parameter int CMT_ENTRIES = msrh_pkg::CMT_DEPTH,  // must equal 2^(CMT_BLK_W-1)
  parameter int DISP_SIZE   = msrh_conf_pkg::DISP_SIZE,
  parameter int DONE_PORTS  = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,

  input  logic                                   i_disp_valid,
  output logic                                   o_disp_ready,
  input  logic [DISP_SIZE-1:0]                   i_disp_inst_valid,
  input  logic [DISP_SIZE-1:0]                   i_disp_rd_valid,
  input  logic [DISP_SIZE-1:0][4:0]              i_disp_rd_regidx,
  input  logic [DISP_SIZE-1:0][RNID_W-1:0]       i_disp_rd_rnid,
  input  logic [DISP_SIZE-1:0][RNID_W-1:0]       i_disp_old_rnid,
  input  logic                                   i_disp_is_br_included,
  output logic [CMT_BLK_W-1:0]                   o_new_cmt_id,

  input  logic [DONE_PORTS-1:0]                  i_done_valid,
  input  logic [DONE_PORTS-1:0][CMT_BLK_W-1:0]   i_done_cmt_id,
  input  logic [DONE_PORTS-1:0][CMT_SLOT_W-1:0]  i_done_slot,
  input  logic [DONE_PORTS-1:0]                  i_done_mispred,

  output cmt_rnid_upd_t                          o_commit_rnid_update,
  output logic                                   o_flush
);

  localparam int IDX_W = $clog2(CMT_ENTRIES);

  cmt_id_t  head_q, head_d;
  cmt_id_t  tail_q, tail_d;
  cmt_grp_t entry_q [CMT_ENTRIES];
  cmt_grp_t entry_d [CMT_ENTRIES];
  cmt_grp_t head_entry;
  cmt_grp_t new_entry;

  logic empty;
  logic full;
  logic commit_vld;
  logic flush;
  logic accept;

  logic [DONE_PORTS-1:0][CMT_ENTRIES-1:0][DISP_SIZE-1:0] port_done;
  logic [DONE_PORTS-1:0][CMT_ENTRIES-1:0][DISP_SIZE-1:0] port_mis;
  logic [CMT_ENTRIES-1:0][DISP_SIZE-1:0]                 done_set;
  logic [CMT_ENTRIES-1:0][DISP_SIZE-1:0]                 mis_set;

  // ---------------------------------------------------------------------------
  // Occupancy and handshake, derived from registered pointers only.
  // ---------------------------------------------------------------------------
  assign empty        = (head_q == tail_q);
  assign full         = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                        (head_q[IDX_W] != tail_q[IDX_W]);
  assign o_disp_ready = !full;
  assign o_new_cmt_id = tail_q;

  assign head_entry = entry_q[head_q[IDX_W-1:0]];
  assign commit_vld = !i_reset && !empty && (&head_entry.done);
  assign flush      = commit_vld && (|head_entry.mispred);
  assign o_flush    = flush;
  // A mispredict commit discards everything younger, including this cycle's group.
  assign accept     = i_disp_valid && o_disp_ready && !flush;

  // ---------------------------------------------------------------------------
  // Per-port decode of completion reports into entry/slot one-hots.
  // Reports to IDs outside [head, tail) are dropped here.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < DONE_PORTS; p++) begin : g_done_port
    logic hit;
    assign hit = i_done_valid[p] && cmt_id_is_live(i_done_cmt_id[p], head_q, tail_q);
    for (genvar e = 0; e < CMT_ENTRIES; e++) begin : g_ent
      for (genvar s = 0; s < DISP_SIZE; s++) begin : g_slot
        logic sel;
        assign sel = hit && (i_done_cmt_id[p][IDX_W-1:0] == IDX_W'(e)) &&
                     (i_done_slot[p] == CMT_SLOT_W'(s));
        assign port_done[p][e][s] = sel;
        assign port_mis[p][e][s]  = sel && i_done_mispred[p];
      end
    end
  end

  // OR-merge all ports so several reports to one group land together.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    done_set = '0;
    mis_set  = '0;
    for (int p = 0; p < DONE_PORTS; p++) begin
      done_set = done_set | port_done[p];
      mis_set  = mis_set  | port_mis[p];
    end
  end

  // Build the entry captured at dispatch; invalid slots start out complete.
  always_comb begin
    new_entry                = '0;
    new_entry.inst_valid     = i_disp_inst_valid;
    new_entry.rd_valid       = i_disp_rd_valid;
    new_entry.rd_regidx      = i_disp_rd_regidx;
    new_entry.rd_rnid        = i_disp_rd_rnid;
    new_entry.old_rnid       = i_disp_old_rnid;
    new_entry.is_br_included = i_disp_is_br_included;
    new_entry.done           = ~i_disp_inst_valid;
    new_entry.mispred        = '0;
  end

  // Next entry contents: write the tail slot on accept, merge completions elsewhere.
  always_comb begin
    entry_d = entry_q;
    for (int e = 0; e < CMT_ENTRIES; e++) begin
      if (accept && (tail_q[IDX_W-1:0] == IDX_W'(e))) begin
        entry_d[e] = new_entry;
      end else begin
        entry_d[e].done    = entry_q[e].done | done_set[e];
        entry_d[e].mispred = entry_q[e].mispred | mis_set[e];
      end
    end
  end

  // Next head/tail: retire one group; a mispredict collapses tail onto the new head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (commit_vld) begin
      head_d = head_q + cmt_id_t'(1);
    end
    if (flush) begin
      tail_d = head_q + cmt_id_t'(1);
    end else if (accept) begin
      tail_d = tail_q + cmt_id_t'(1);
    end
  end

  // Commit update driven from the head entry; all-zero when nothing retires.
  always_comb begin
    logic older_mis;
    o_commit_rnid_update = '0;
    older_mis            = 1'b0;
    if (commit_vld) begin
      o_commit_rnid_update.commit         = 1'b1;
      o_commit_rnid_update.rnid_valid     = head_entry.rd_valid & head_entry.inst_valid;
      o_commit_rnid_update.rd_regidx      = head_entry.rd_regidx;
      o_commit_rnid_update.rd_rnid        = head_entry.rd_rnid;
      o_commit_rnid_update.old_rnid       = head_entry.old_rnid;
      o_commit_rnid_update.is_br_included = head_entry.is_br_included;
      o_commit_rnid_update.upd_pc_valid   = |head_entry.mispred;
      for (int s = 0; s < DISP_SIZE; s++) begin
        o_commit_rnid_update.dead_id[s] = older_mis;
        older_mis = older_mis | head_entry.mispred[s];
      end
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    // NOTE: entries carry no reset; liveness comes solely from head/tail, and each slot is fully rewritten on accept.
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_msrh_rnid_commit_tracker.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the in-order commit buffer.
module tb_msrh_rnid_commit_tracker;
  import msrh_pkg::*;

  localparam int DS    = msrh_conf_pkg::DISP_SIZE;
  localparam int NP    = 4;
  localparam int DEPTH = 16;
  localparam int IDMOD = 1 << CMT_BLK_W;

  logic                                clk;
  logic                                reset;
  logic                                disp_valid;
  logic                                disp_ready;
  logic [DS-1:0]                       disp_iv;
  logic [DS-1:0]                       disp_rv;
  logic [DS-1:0][4:0]                  disp_regidx;
  logic [DS-1:0][RNID_W-1:0]           disp_rnid;
  logic [DS-1:0][RNID_W-1:0]           disp_old;
  logic                                disp_br;
  logic [CMT_BLK_W-1:0]                new_id;
  logic [NP-1:0]                       done_valid;
  logic [NP-1:0][CMT_BLK_W-1:0]        done_id;
  logic [NP-1:0][CMT_SLOT_W-1:0]       done_slot;
  logic [NP-1:0]                       done_mis;
  cmt_rnid_upd_t                       upd;
  logic                                flush;

  msrh_rnid_commit_tracker #(.CMT_ENTRIES(DEPTH), .DISP_SIZE(DS), .DONE_PORTS(NP)) dut (
    .i_clk                 (clk),
    .i_reset               (reset),
    .i_disp_valid          (disp_valid),
    .o_disp_ready          (disp_ready),
    .i_disp_inst_valid     (disp_iv),
    .i_disp_rd_valid       (disp_rv),
    .i_disp_rd_regidx      (disp_regidx),
    .i_disp_rd_rnid        (disp_rnid),
    .i_disp_old_rnid       (disp_old),
    .i_disp_is_br_included (disp_br),
    .o_new_cmt_id          (new_id),
    .i_done_valid          (done_valid),
    .i_done_cmt_id         (done_id),
    .i_done_slot           (done_slot),
    .i_done_mispred        (done_mis),
    .o_commit_rnid_update  (upd),
    .o_flush               (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of live groups in program order, oldest first.
  typedef struct {
    logic [DS-1:0]             iv;
    logic [DS-1:0]             rv;
    logic [DS-1:0][4:0]        regidx;
    logic [DS-1:0][RNID_W-1:0] rnid;
    logic [DS-1:0][RNID_W-1:0] old;
    logic                      br;
    logic [DS-1:0]             done;
    logic [DS-1:0]             mis;
  } mgrp_t;

  mgrp_t q[$];
  int    m_head;
  int    total;
  int    bad;

  logic                 exp_ready, act_ready;
  logic [CMT_BLK_W-1:0] exp_id, act_id;
  cmt_rnid_upd_t        exp_upd, act_upd;
  logic                 exp_flush, act_flush;

  task automatic idle();
    disp_valid = 1'b0;
    disp_iv    = '0;
    disp_rv    = '0;
    disp_br    = 1'b0;
    done_valid = '0;
    done_mis   = '0;
  endtask

  // Offer a group: slot 0 given explicitly, remaining slots random.
  task automatic offer(input logic [DS-1:0] iv, input logic [DS-1:0] rv,
                       input logic [4:0] r0, input logic [RNID_W-1:0] n0,
                       input logic [RNID_W-1:0] o0);
    disp_valid     = 1'b1;
    disp_iv        = iv;
    disp_rv        = rv;
    disp_br        = 1'($urandom);
    disp_regidx[0] = r0;
    disp_rnid[0]   = n0;
    disp_old[0]    = o0;
    for (int s = 1; s < DS; s++) begin
      disp_regidx[s] = 5'($urandom);
      disp_rnid[s]   = RNID_W'($urandom);
      disp_old[s]    = RNID_W'($urandom);
    end
  endtask

  task automatic offer_full();
    offer('1, DS'($urandom), 5'($urandom), RNID_W'($urandom), RNID_W'($urandom));
  endtask

  task automatic report(input int p, input int id, input int slot, input bit mis);
    done_valid[p] = 1'b1;
    done_id[p]    = CMT_BLK_W'(id);
    done_slot[p]  = CMT_SLOT_W'(slot);
    done_mis[p]   = mis;
  endtask

  task automatic report_group(input int id, input int port_base);
    for (int s = 0; s < DS; s++) report(port_base + s, id, s, 1'b0);
  endtask

  // One clock: predict outputs from the model, sample the DUT, advance both.
  task automatic cycle();
    mgrp_t h;
    mgrp_t g;
    bit    cmt;
    bit    fl;
    int    low;
    int    off;
    #1;
    exp_ready = (q.size() < DEPTH);
    exp_id    = CMT_BLK_W'((m_head + q.size()) % IDMOD);
    exp_upd   = '0;
    cmt       = 1'b0;
    fl        = 1'b0;
    if (!reset && q.size() > 0 && q[0].done == {DS{1'b1}}) begin
      h   = q[0];
      cmt = 1'b1;
      fl  = (h.mis != '0);
      low = -1;
      for (int s = DS - 1; s >= 0; s--) if (h.mis[s]) low = s;
      exp_upd.commit         = 1'b1;
      exp_upd.rnid_valid     = h.rv & h.iv;
      exp_upd.rd_regidx      = h.regidx;
      exp_upd.rd_rnid        = h.rnid;
      exp_upd.old_rnid       = h.old;
      exp_upd.is_br_included = h.br;
      exp_upd.upd_pc_valid   = fl;
      for (int s = 0; s < DS; s++) exp_upd.dead_id[s] = (low >= 0) && (s > low);
    end
    exp_flush = fl;
    act_ready = disp_ready;
    act_id    = new_id;
    act_upd   = upd;
    act_flush = flush;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_head = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (done_valid[p]) begin
          off = (int'(done_id[p]) - m_head) & (IDMOD - 1);
          if (off < q.size()) begin
            g = q[off];
            g.done[done_slot[p]] = 1'b1;
            if (done_mis[p]) g.mis[done_slot[p]] = 1'b1;
            q[off] = g;
          end
        end
      end
      if (cmt) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % IDMOD;
        if (fl) q.delete();
      end
      if (disp_valid && exp_ready && !fl) begin
        g.iv = disp_iv; g.rv = disp_rv; g.regidx = disp_regidx;
        g.rnid = disp_rnid; g.old = disp_old; g.br = disp_br;
        g.done = ~disp_iv; g.mis = '0;
        q.push_back(g);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", act_ready); end
    total++; if (act_id !== '0) begin bad++; $display("FAIL reset_cmt_id got=%0d want=0", act_id); end
    total++; if (act_upd !== '0) begin bad++; $display("FAIL reset_update got=%h want=0", act_upd); end
    total++; if (act_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b want=0", act_flush); end
  endtask

  task automatic test_single_group();
    offer(DS'(1), DS'(1), 5'd5, RNID_W'(40), RNID_W'(5));
    cycle();
    idle();
    cycle();
    report(0, 0, 0, 1'b0);
    cycle();
    total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL single_early_commit got=%0b want=0", act_upd.commit); end
    idle();
    cycle();
    total++; if (act_upd.commit !== 1'b1) begin bad++; $display("FAIL single_commit got=%0b want=1", act_upd.commit); end
    total++; if (act_upd.rnid_valid !== DS'(1)) begin bad++; $display("FAIL single_rnid_valid got=%b want=%b", act_upd.rnid_valid, DS'(1)); end
    total++; if (act_upd.old_rnid[0] !== RNID_W'(5)) begin bad++; $display("FAIL single_old_rnid got=%0d want=5", act_upd.old_rnid[0]); end
    total++; if (act_upd.rd_rnid[0] !== RNID_W'(40)) begin bad++; $display("FAIL single_rd_rnid got=%0d want=40", act_upd.rd_rnid[0]); end
    total++; if (act_upd !== exp_upd) begin bad++; $display("FAIL single_update got=%h want=%h", act_upd, exp_upd); end
    cycle();
    total++; if (act_id !== CMT_BLK_W'(1)) begin bad++; $display("FAIL single_head_adv got=%0d want=1", act_id); end
    total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL single_idle_commit got=%0b want=0", act_upd.commit); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      offer_full();
      cycle();
      total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%0b want=1", i, act_ready); end
      total++; if (act_id !== CMT_BLK_W'(i)) begin bad++; $display("FAIL fill_id[%0d] got=%0d want=%0d", i, act_id, i); end
    end
    idle();
    cycle();
    total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", act_ready); end
    total++; if (act_id !== CMT_BLK_W'(DEPTH)) begin bad++; $display("FAIL full_id got=%0d want=%0d", act_id, DEPTH); end
    offer_full();
    report_group(0, 0);
    cycle();
    done_valid = '0;
    cycle();
    total++; if (act_upd.commit !== 1'b1) begin bad++; $display("FAIL full_commit got=%0b want=1", act_upd.commit); end
    total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL full_commit_ready got=%0b want=0", act_ready); end
    total++; if (act_upd !== exp_upd) begin bad++; $display("FAIL full_update got=%h want=%h", act_upd, exp_upd); end
    idle();
    cycle();
    total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL after_commit_ready got=%0b want=1", act_ready); end
    total++; if (act_id !== exp_id) begin bad++; $display("FAIL after_commit_id got=%0d want=%0d", act_id, exp_id); end
  endtask

  task automatic test_out_of_order();
    int h;
    h = m_head;
    report_group((h + 1) % IDMOD, 0);
    cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL ooo_hold[%0d] got=%0b want=0", i, act_upd.commit); end
    end
    report_group(h, 0);
    cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++; if (act_upd.commit !== 1'b1) begin bad++; $display("FAIL ooo_commit[%0d] got=%0b want=1", i, act_upd.commit); end
      total++; if (act_upd !== exp_upd) begin bad++; $display("FAIL ooo_update[%0d] got=%h want=%h", i, act_upd, exp_upd); end
    end
    cycle();
    total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL ooo_after got=%0b want=0", act_upd.commit); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      offer_full();
      cycle();
    end
    idle();
    report_group(0, 0);
    report_group(1, 2);
    cycle();
    idle();
    cycle();
    cycle();
    report(0, 2, 0, 1'b1);
    report(1, 2, 1, 1'b0);
    cycle();
    idle();
    offer_full();
    cycle();
    total++; if (act_upd.commit !== 1'b1) begin bad++; $display("FAIL mis_commit got=%0b want=1", act_upd.commit); end
    total++; if (act_upd.upd_pc_valid !== 1'b1) begin bad++; $display("FAIL mis_pc_valid got=%0b want=1", act_upd.upd_pc_valid); end
    total++; if (act_upd.dead_id !== DS'(2)) begin bad++; $display("FAIL mis_dead_id got=%b want=%b", act_upd.dead_id, DS'(2)); end
    total++; if (act_flush !== 1'b1) begin bad++; $display("FAIL mis_flush got=%0b want=1", act_flush); end
    total++; if (act_upd !== exp_upd) begin bad++; $display("FAIL mis_update got=%h want=%h", act_upd, exp_upd); end
    idle();
    cycle();
    total++; if (act_id !== CMT_BLK_W'(3)) begin bad++; $display("FAIL mis_tail got=%0d want=3", act_id); end
    total++; if (act_flush !== 1'b0) begin bad++; $display("FAIL mis_flush_after got=%0b want=0", act_flush); end
  endtask

  task automatic test_stale_done();
    report_group(3, 0);
    report_group(4, 2);
    cycle();
    idle();
    cycle();
    total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL stale_commit got=%0b want=0", act_upd.commit); end
    total++; if (act_id !== CMT_BLK_W'(3)) begin bad++; $display("FAIL stale_id got=%0d want=3", act_id); end
    offer_full();
    cycle();
    idle();
    cycle();
    cycle();
    total++; if (act_upd.commit !== 1'b0) begin bad++; $display("FAIL stale_preset got=%0b want=0", act_upd.commit); end
    report_group(3, 0);
    cycle();
    idle();
    cycle();
    total++; if (act_upd.commit !== 1'b1) begin bad++; $display("FAIL stale_real_done got=%0b want=1", act_upd.commit); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      offer_full();
      cycle();
    end
    idle();
    report_group(m_head, 0);
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    total++; if (act_upd !== '0) begin bad++; $display("FAIL rst_mid_update got=%h want=0", act_upd); end
    total++; if (act_flush !== 1'b0) begin bad++; $display("FAIL rst_mid_flush got=%0b want=0", act_flush); end
    reset = 1'b0;
    cycle();
    total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%0b want=1", act_ready); end
    total++; if (act_id !== '0) begin bad++; $display("FAIL rst_mid_id got=%0d want=0", act_id); end
    total++; if (act_upd !== '0) begin bad++; $display("FAIL rst_mid_after got=%h want=0", act_upd); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      disp_valid = ($urandom_range(0, 2) != 0);
      disp_iv    = DS'($urandom);
      disp_rv    = DS'($urandom);
      disp_br    = 1'($urandom);
      for (int s = 0; s < DS; s++) begin
        disp_regidx[s] = 5'($urandom);
        disp_rnid[s]   = RNID_W'($urandom);
        disp_old[s]    = RNID_W'($urandom);
      end
      for (int p = 0; p < NP; p++) begin
        done_valid[p] = 1'($urandom);
        done_id[p]    = CMT_BLK_W'(m_head + $urandom_range(0, q.size() + 1));
        done_slot[p]  = CMT_SLOT_W'($urandom_range(0, DS - 1));
        done_mis[p]   = ($urandom_range(0, 24) == 0);
      end
      cycle();
      total++; if (act_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%0b want=%0b", c, act_ready, exp_ready); end
      total++; if (act_id !== exp_id) begin bad++; $display("FAIL rnd_id[%0d] got=%0d want=%0d", c, act_id, exp_id); end
      total++; if (act_upd !== exp_upd) begin bad++; $display("FAIL rnd_update[%0d] got=%h want=%h", c, act_upd, exp_upd); end
      total++; if (act_flush !== exp_flush) begin bad++; $display("FAIL rnd_flush[%0d] got=%0b want=%0b", c, act_flush, exp_flush); end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    m_head      = 0;
    reset       = 1'b1;
    disp_regidx = '0;
    disp_rnid   = '0;
    disp_old    = '0;
    done_id     = '0;
    done_slot   = '0;
    idle();
    test_reset();
    test_single_group();
    test_fill();
    test_out_of_order();
    test_mispredict();
    test_stale_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrh_rnid_commit_tracker.md
# msrh_rnid_commit_tracker

Commit-side producer of `msrh_pkg::cmt_rnid_upd_t`, the rename-ID update consumed by the rename stage. It records each dispatched group in an in-order buffer together with its rd / old-rd rename IDs, and tracks per-slot completion. When the oldest group is fully complete it emits one commit update that frees old RNIDs and, on mispredict, restores the rename map. It sits between the dispatch/rename output and the rename freelist/map, and supplies `cmt_id` back to dispatch.

## Interface
Parameters:
- `CMT_ENTRIES`, 16: group entries; power of two.
- `DISP_SIZE`, `msrh_conf_pkg::DISP_SIZE`: slots per group.
- `DONE_PORTS`, 4: completion report ports per cycle.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous active-high reset.
- `i_disp_valid`  in  1  dispatch group offered.
- `o_disp_ready`  out  1  entry free; group accepted when valid & ready.
- `i_disp_inst_valid`  in  DISP_SIZE  per-slot valid.
- `i_disp_rd_valid`  in  DISP_SIZE  slot writes rd.
- `i_disp_rd_regidx`  in  DISP_SIZE×5  arch rd.
- `i_disp_rd_rnid`  in  DISP_SIZE×RNID_W  new RNID.
- `i_disp_old_rnid`  in  DISP_SIZE×RNID_W  previous mapping of rd.
- `i_disp_is_br_included`  in  1  group contains a branch (snapshot taken).
- `o_new_cmt_id`  out  CMT_BLK_W  ID the next accepted group receives.
- `i_done_valid`  in  DONE_PORTS  completion report.
- `i_done_cmt_id`  in  DONE_PORTS×CMT_BLK_W  group.
- `i_done_slot`  in  DONE_PORTS×log2(DISP_SIZE)  slot.
- `i_done_mispred`  in  DONE_PORTS  slot is a mispredicted branch.
- `o_commit_rnid_update`  out  cmt_rnid_upd_t  commit update.
- `o_flush`  out  1  younger groups discarded this cycle.

## Operation
- Circular buffer, head/tail pointers of CMT_BLK_W = log2(CMT_ENTRIES)+1 bits; MSB is the wrap bit. Empty: head==tail. Full: index bits equal and wrap bits differ.
- `o_new_cmt_id` = tail. `o_disp_ready` = !full, computed from registered state only. A commit in the same cycle does not make room that cycle.
- On accept: write the entry at tail; tail+1. `done` bits are preset to 1 for invalid slots and 0 for valid slots; `mispred` bits are cleared.
- Done port p with a valid, live `cmt_id`: set `done[slot]`; if `i_done_mispred`, set `mispred[slot]`. Reports to non-live IDs are ignored. Multiple ports may hit the same entry; their results are OR-merged.
- Head complete = non-empty & all done bits set. Then `o_commit_rnid_update` is driven combinationally from the head entry, and head advances at the clock edge:
  - `commit`=1.
  - `rnid_valid` = rd_valid & inst_valid.
  - `rd_regidx`, `rd_rnid`, `old_rnid` copied from the entry.
  - `is_br_included` copied from the entry.
  - `upd_pc_valid` = any mispred.
  - `dead_id`: slots strictly younger than the lowest mispred slot.
- Mispredict commit: `o_flush`=1 the same cycle; tail ← head+1 (all younger groups dropped); accepts that cycle are discarded.
- When not committing, every field of `o_commit_rnid_update` is 0.

## Timing
- Reset: head=tail=0, all entries invalid. `o_disp_ready`=1, `o_new_cmt_id`=0, `o_commit_rnid_update`=0, `o_flush`=0.
- Dispatch accepted in cycle N → entry live at N+1.
- Done in cycle N → commit output in cycle N+1 at earliest.
- At most one group commits per cycle.
- Dispatch and commit in the same cycle (not full) both take effect.
- A done report for the head in the commit cycle is irrelevant; the head is already complete.
- Reset asserted mid-operation clears everything the next edge; no commit output in the reset cycle.
- Pointer wrap: the wrap bit toggles; IDs are compared with the full CMT_BLK_W width.

## Structure
- Entry struct `cmt_grp_t`, CMT_BLK_W, RNID_W, and `cmt_rnid_upd_t` live in `msrh_pkg`.
- Liveness check (`id` in [head, tail) with wrap) is a package function.
- No sub-module; a single module with a generate loop over DONE_PORTS.

## Test plan
- Reset, then dispatch one group: slot0 rd x5 rnid 40 old 5; done(0,0) at cycle 3 → commit at cycle 4 with rnid_valid=01, old_rnid[0]=5, rd_rnid[0]=40; head=1.
- Fill 16 groups → `o_disp_ready`=0 on cycle 16; `o_new_cmt_id`=16 (wrap bit set). Commit head → ready=1 the next cycle.
- Out-of-order done: group 1 done before group 0 → no commit until group 0 done, then commits in order on consecutive cycles.
- Mispredict on slot 0 of group 2, groups 3–5 live → commit: upd_pc_valid=1, dead_id=10, `o_flush`=1; next cycle tail=3 and the buffer is empty.
- Done for a stale cmt_id after flush → no state change, no commit.
- Reset asserted while 5 groups are live → next cycle empty, ready=1, cmt_id=0, no commit output.
